// File: rtl/motor_pwm_sched_if.sv
// Command and pwm-channel bundle between the flight controller, the motor scheduler
// and the four pwm channels.
interface motor_pwm_sched_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_speed;
  logic [3:0]  ch_busy;
  logic [63:0] ch_speed;
  logic [3:0]  ch_oe;

  modport master (
    output cmd_valid,
    output cmd_speed,
    output ch_busy,
    input  cmd_ready,
    input  ch_speed,
    input  ch_oe
  );

  modport slave (
    input  cmd_valid,
    input  cmd_speed,
    input  ch_busy,
    output cmd_ready,
    output ch_speed,
    output ch_oe
  );
endinterface

// File: rtl/motor_pwm_sched.sv
// Frame scheduler for four motor pwm channels: clamp, slew limit, per-channel load with
// busy timeout, arming, command-loss watchdog and immediate motor cut.
module motor_pwm_sched #(
  parameter logic [15:0] MIN_SPEED   = 16'd1000,
  parameter logic [15:0] MAX_SPEED   = 16'd60000,
  parameter logic [15:0] MAX_STEP    = 16'd2000,
  parameter logic [23:0] WDOG_CYCLES = 24'd1_000_000,
  parameter logic [15:0] BUSY_TMO    = 16'd1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  motor_pwm_sched_if.slave bus,
  output logic             armed,
  output logic             failsafe,
  output logic             busy_err,
  output logic             frame_done
);

  typedef enum logic [1:0] {StIdle, StWait, StStrobe, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] wait_q, wait_d;
  logic [23:0] wdog_q, wdog_d;
  logic        cut_q, cut_d;
  logic        pend_q, pend_d;
  logic        armed_q, armed_d;
  logic        fs_q, fs_d;
  logic        berr_q, berr_d;
  logic [15:0] target_q [4];
  logic [15:0] target_d [4];
  logic [15:0] cur_q [4];
  logic [15:0] cur_d [4];
  logic        accept;
  logic [15:0] cur_sel, tgt_sel, new_speed, down;
  logic [16:0] up;

  function automatic logic [15:0] clamp_speed(input logic [15:0] v);
    if (v < MIN_SPEED)      return MIN_SPEED;
    else if (v > MAX_SPEED) return MAX_SPEED;
    else                    return v;
  endfunction

  // Slew limit with a 17-bit ceiling and a floored step-down so neither side can wrap.
  always_comb begin
    cur_sel = cur_q[idx_q];
    tgt_sel = target_q[idx_q];
    up      = {1'b0, cur_sel} + {1'b0, MAX_STEP};
    down    = (cur_sel > MAX_STEP) ? cur_sel - MAX_STEP : 16'd0;
    if (cut_q || !armed_q || fs_q) begin
      new_speed = MIN_SPEED;
    end else if (tgt_sel > cur_sel) begin
      new_speed = ({1'b0, tgt_sel} < up) ? tgt_sel : up[15:0];
    end else begin
      new_speed = (tgt_sel > down) ? tgt_sel : down;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wait_d        = wait_q;
    cut_d         = cut_q;
    pend_d        = pend_q;
    berr_d        = berr_q;
    target_d      = target_q;
    cur_d         = cur_q;
    accept        = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.ch_oe     = 4'b0;
    frame_done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.cmd_ready = !pend_q && !rst;
        if (pend_q) begin
          pend_d  = 1'b0;
          cut_d   = 1'b1;
          idx_d   = 2'd0;
          wait_d  = 16'd0;
          state_d = StWait;
        end else if (bus.cmd_valid && !rst) begin
          accept  = 1'b1;
          cut_d   = 1'b0;
          idx_d   = 2'd0;
          wait_d  = 16'd0;
          state_d = StWait;
          for (int i = 0; i < 4; i++) begin
            target_d[i] = armed_q ? clamp_speed(bus.cmd_speed[16*i +: 16]) : MIN_SPEED;
          end
        end
      end
      StWait: begin
        if (!bus.ch_busy[idx_q]) begin
          state_d = StStrobe;
        end else if (wait_q == BUSY_TMO - 16'd1) begin
          berr_d  = 1'b1;
          wait_d  = 16'd0;
          state_d = (idx_q == 2'd3) ? StDone : StWait;
          idx_d   = idx_q + 2'd1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      StStrobe: begin
        bus.ch_oe[idx_q] = 1'b1;
        cur_d[idx_q]     = new_speed;
        wait_d           = 16'd0;
        state_d          = (idx_q == 2'd3) ? StDone : StWait;
        idx_d            = idx_q + 2'd1;
      end
      StDone: begin
        frame_done = 1'b1;
        state_d    = StIdle;
      end
    endcase

    armed_d = armed_q;
    if (!arm)                    armed_d = 1'b0;
    else if (state_q == StIdle)  armed_d = 1'b1;
    if (armed_q && !arm)         pend_d  = 1'b1;

    wdog_d = wdog_q;
    fs_d   = fs_q;
    if (accept) begin
      wdog_d = 24'd0;
      fs_d   = 1'b0;
    end else begin
      if (wdog_q != WDOG_CYCLES - 24'd1) wdog_d = wdog_q + 24'd1;
      // Trip once on the step into saturation so the cut frame is issued only once.
      if (wdog_q == WDOG_CYCLES - 24'd2) begin
        fs_d   = 1'b1;
        pend_d = 1'b1;
      end
    end

    for (int i = 0; i < 4; i++) begin
      bus.ch_speed[16*i +: 16] = cur_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      wait_q  <= 16'd0;
      wdog_q  <= 24'd0;
      cut_q   <= 1'b0;
      pend_q  <= 1'b0;
      armed_q <= 1'b0;
      fs_q    <= 1'b0;
      berr_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cur_q[i]    <= MIN_SPEED;
        target_q[i] <= MIN_SPEED;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
      wdog_q   <= wdog_d;
      cut_q    <= cut_d;
      pend_q   <= pend_d;
      armed_q  <= armed_d;
      fs_q     <= fs_d;
      berr_q   <= berr_d;
      cur_q    <= cur_d;
      target_q <= target_d;
    end
  end

  assign armed    = armed_q;
  assign failsafe = fs_q;
  assign busy_err = berr_q;

endmodule

// File: tb/tb_motor_pwm_sched.sv
// Scoreboard bench for motor_pwm_sched: expected strobes are queued when commands are
// driven and popped as the scheduler loads each channel.
module tb_motor_pwm_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arm = 1'b0;
  logic armed, failsafe, busy_err, frame_done;

  motor_pwm_sched_if bus ();

  motor_pwm_sched #(
    .MIN_SPEED  (16'd1000),
    .MAX_SPEED  (16'd60000),
    .MAX_STEP   (16'd2000),
    .WDOG_CYCLES(24'd100),
    .BUSY_TMO   (16'd16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arm       (arm),
    .bus       (bus),
    .armed     (armed),
    .failsafe  (failsafe),
    .busy_err  (busy_err),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_strobe [4];
  int exp_ch [$];
  int exp_spd [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic push_exp(input int ch, input int spd);
    exp_ch.push_back(ch);
    exp_spd.push_back(spd);
  endtask

  task automatic push4(input int a, input int b, input int c, input int d);
    push_exp(0, a);
    push_exp(1, b);
    push_exp(2, c);
    push_exp(3, d);
  endtask

  // Scoreboard: every strobe must match the next queued channel and speed.
  always @(negedge clk) begin
    int ch;
    int e_ch;
    int e_spd;
    if (!rst && bus.ch_oe != 4'b0) begin
      ch = 0;
      check_eq("oe_onehot", 64'($countones(bus.ch_oe)), 64'd1);
      for (int i = 0; i < 4; i++) if (bus.ch_oe[i]) ch = i;
      last_strobe[ch] = cyc;
      if (exp_ch.size() == 0) begin
        check_eq("oe_unexpected", 64'(bus.ch_oe), 64'd0);
      end else begin
        e_ch  = exp_ch.pop_front();
        e_spd = exp_spd.pop_front();
        check_eq("strobe_ch", 64'(ch), 64'(e_ch));
        check_eq("strobe_speed", 64'(bus.ch_speed[16*ch +: 16]), 64'(e_spd));
      end
    end
  end

  task automatic send_cmd(input logic [63:0] spd, output int acc);
    acc = -1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_speed = spd;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) check_eq("accept_timeout", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (frame_done) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) check_eq("done_timeout", 64'(frame_done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int dc;
    int rel;
    bus.cmd_valid = 1'b0;
    bus.cmd_speed = '0;
    bus.ch_busy   = 4'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_oe", 64'(bus.ch_oe), 64'd0);
    check_eq("rst_ready", 64'(bus.cmd_ready), 64'd0);
    check_eq("rst_flags", 64'({armed, failsafe, busy_err, frame_done}), 64'd0);
    check_eq("rst_speed", bus.ch_speed, pack4(1000, 1000, 1000, 1000));
    @(posedge clk); #1;
    rst = 1'b0;
    arm = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("armed_rise", 64'(armed), 64'd1);

    // 1: clamp and slew from idle, frame timing.
    push4(1500, 3000, 3000, 3000);
    send_cmd(pack4(1500, 3000, 5000, 65000), acc);
    wait_done(dc);
    check_eq("t1_done_cyc", 64'(dc), 64'(acc + 9));
    for (int i = 0; i < 4; i++) check_eq("t1_strobe_cyc", 64'(last_strobe[i]), 64'(acc + 2 + 2*i));
    check_eq("t1_ready_low", 64'(bus.cmd_ready), 64'd0);
    @(negedge clk);
    check_eq("t1_ready_high", 64'(bus.cmd_ready), 64'd1);
    check_eq("t1_hold", bus.ch_speed, pack4(1500, 3000, 3000, 3000));

    // 2: repeated command keeps slewing up, then slew down.
    push4(1500, 3000, 5000, 5000);
    send_cmd(pack4(1500, 3000, 5000, 65000), acc);
    wait_done(dc);
    push4(1000, 1000, 3000, 3000);
    send_cmd(pack4(1000, 1000, 1000, 1000), acc);
    wait_done(dc);
    check_eq("t2_hold", bus.ch_speed, pack4(1000, 1000, 3000, 3000));

    // 3: ch1 busy holds the frame; strobe follows busy release by one cycle.
    bus.ch_busy = 4'b0010;
    push4(2000, 2000, 2000, 2000);
    send_cmd(pack4(2000, 2000, 2000, 2000), acc);
    repeat (9) @(posedge clk);
    #1;
    bus.ch_busy = 4'b0000;
    rel = cyc;
    wait_done(dc);
    check_eq("t3_ch0_cyc", 64'(last_strobe[0]), 64'(acc + 2));
    check_eq("t3_ch1_cyc", 64'(last_strobe[1]), 64'(rel + 1));
    check_eq("t3_no_berr", 64'(busy_err), 64'd0);

    // 4: ch2 stuck busy is skipped after the timeout.
    bus.ch_busy = 4'b0100;
    push_exp(0, 4000);
    push_exp(1, 4000);
    push_exp(3, 4000);
    send_cmd(pack4(4000, 4000, 4000, 4000), acc);
    wait_done(dc);
    check_eq("t4_ch3_cyc", 64'(last_strobe[3]), 64'(acc + 22));
    check_eq("t4_done_cyc", 64'(dc), 64'(acc + 23));
    check_eq("t4_berr", 64'(busy_err), 64'd1);
    check_eq("t4_hold", bus.ch_speed, pack4(4000, 4000, 2000, 4000));
    bus.ch_busy = 4'b0000;

    // 5: watchdog expiry forces a cut frame; next command clears failsafe.
    push4(1000, 1000, 1000, 1000);
    while (cyc < acc + 99) @(negedge clk);
    check_eq("t5_fs_before", 64'(failsafe), 64'd0);
    @(negedge clk);
    check_eq("t5_fs_cyc", 64'(cyc), 64'(acc + 100));
    check_eq("t5_fs_set", 64'(failsafe), 64'd1);
    check_eq("t5_ready_cut", 64'(bus.cmd_ready), 64'd0);
    wait_done(dc);
    check_eq("t5_cut_hold", bus.ch_speed, pack4(1000, 1000, 1000, 1000));
    push4(3000, 3000, 3000, 3000);
    send_cmd(pack4(5000, 5000, 5000, 5000), acc);
    @(negedge clk);
    check_eq("t5_fs_clear", 64'(failsafe), 64'd0);
    wait_done(dc);
    check_eq("t4_berr_sticky", 64'(busy_err), 64'd1);

    // 6: disarm during WAIT ch1: rest of frame cut, then a cut frame, then MIN while disarmed.
    push4(5000, 1000, 1000, 1000);
    push4(1000, 1000, 1000, 1000);
    send_cmd(pack4(5000, 5000, 5000, 5000), acc);
    repeat (2) @(posedge clk);
    #1;
    arm = 1'b0;
    wait_done(dc);
    check_eq("t6_armed_low", 64'(armed), 64'd0);
    wait_done(dc);
    check_eq("t6_cut_hold", bus.ch_speed, pack4(1000, 1000, 1000, 1000));
    push4(1000, 1000, 1000, 1000);
    send_cmd(pack4(5000, 5000, 5000, 5000), acc);
    wait_done(dc);
    check_eq("t6_disarmed_hold", bus.ch_speed, pack4(1000, 1000, 1000, 1000));
    repeat (3) @(negedge clk);
    check_eq("sb_drained", 64'(exp_ch.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
